// File: rtl/read_iq_param.sv
// IQ unpacker: pops packed words from the raw-sample FIFO, splits them into
// signed I/Q pairs, quantises each sample and writes I and Q FIFOs in lockstep.
module read_iq_param #(
    parameter int unsigned IN_WIDTH     = 64,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned QUANT_BITS   = 10,
    parameter int unsigned OUT_WIDTH    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 in_rd_en,
    input  logic                 in_empty,
    input  logic [IN_WIDTH-1:0]  in_dout,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic [OUT_WIDTH-1:0] out_din,
    output logic                 out_wr_en_2,
    input  logic                 out_full_2,
    output logic [OUT_WIDTH-1:0] out_din_2,
    input  logic                 swap_iq,
    output logic [31:0]          sample_count
);

    localparam int unsigned PAIR_W   = 2 * SAMPLE_WIDTH;
    localparam int unsigned PAIRS    = IN_WIDTH / PAIR_W;
    localparam int unsigned IDX_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int unsigned LAST_IDX = PAIRS - 1;

    typedef enum logic {
        S_LOAD,
        S_EMIT
    } state_t;

    state_t              state, state_d;
    logic [IN_WIDTH-1:0] word_r, word_d;
    logic                swap_r, swap_d;
    logic [IDX_W-1:0]    idx_r, idx_d;
    logic [31:0]         count_r, count_d;

    logic                wr_ok;
    logic                last_pair;
    logic [PAIR_W-1:0]   pair_sel;
    logic [OUT_WIDTH-1:0] quant_i;
    logic [OUT_WIDTH-1:0] quant_q;

    // Sign-extend to the output width, then shift left by the quantisation amount.
    function automatic logic [OUT_WIDTH-1:0] quantise(input logic [SAMPLE_WIDTH-1:0] s);
        logic signed [OUT_WIDTH-1:0] ext;
        ext = OUT_WIDTH'($signed(s));
        return ext <<< QUANT_BITS;
    endfunction

    // Select the current pair out of the captured word.
    always_comb begin
        pair_sel = '0;
        for (int k = 0; k < PAIRS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                pair_sel = word_r[k*PAIR_W +: PAIR_W];
            end
        end
    end

    assign quant_i   = quantise(pair_sel[SAMPLE_WIDTH-1:0]);
    assign quant_q   = quantise(pair_sel[PAIR_W-1:SAMPLE_WIDTH]);
    assign out_din   = swap_r ? quant_q : quant_i;
    assign out_din_2 = swap_r ? quant_i : quant_q;

    assign wr_ok        = !out_full && !out_full_2;
    assign last_pair    = (idx_r == IDX_W'(LAST_IDX));
    assign sample_count = count_r;

    // Next-state, register updates and FIFO handshakes.
    always_comb begin
        state_d     = state;
        word_d      = word_r;
        swap_d      = swap_r;
        idx_d       = idx_r;
        count_d     = count_r;
        in_rd_en    = 1'b0;
        out_wr_en   = 1'b0;
        out_wr_en_2 = 1'b0;

        case (state)
            S_LOAD: begin
                // Reset gating keeps the pop low while reset is held.
                if (reset && !in_empty) begin
                    in_rd_en = 1'b1;
                    word_d   = in_dout;
                    swap_d   = swap_iq;
                    idx_d    = '0;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                if (wr_ok) begin
                    out_wr_en   = 1'b1;
                    out_wr_en_2 = 1'b1;
                    count_d     = count_r + 32'd1;
                    if (!last_pair) begin
                        idx_d = idx_r + IDX_W'(1);
                    end else if (!in_empty) begin
                        // Back-to-back reload keeps one pair per cycle across words.
                        in_rd_en = 1'b1;
                        word_d   = in_dout;
                        swap_d   = swap_iq;
                        idx_d    = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_LOAD;
            word_r  <= '0;
            swap_r  <= 1'b0;
            idx_r   <= '0;
            count_r <= '0;
        end else begin
            state   <= state_d;
            word_r  <= word_d;
            swap_r  <= swap_d;
            idx_r   <= idx_d;
            count_r <= count_d;
        end
    end

endmodule

// File: tb/tb_read_iq_param.sv
// Self-checking bench for read_iq_param: FIFO models around the DUT, a
// word-level reference model, directed vectors and randomized streams.
module tb_read_iq_param;

    localparam int unsigned IN_WIDTH     = 64;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned QUANT_BITS   = 10;
    localparam int unsigned OUT_WIDTH    = 32;
    localparam int unsigned PAIRS        = IN_WIDTH / (2 * SAMPLE_WIDTH);

    logic                 clock;
    logic                 reset;
    logic                 in_rd_en;
    logic                 in_empty;
    logic [IN_WIDTH-1:0]  in_dout;
    logic                 out_wr_en;
    logic                 out_full;
    logic [OUT_WIDTH-1:0] out_din;
    logic                 out_wr_en_2;
    logic                 out_full_2;
    logic [OUT_WIDTH-1:0] out_din_2;
    logic                 swap_iq;
    logic [31:0]          sample_count;

    read_iq_param #(
        .IN_WIDTH    (IN_WIDTH),
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .QUANT_BITS  (QUANT_BITS),
        .OUT_WIDTH   (OUT_WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_rd_en    (in_rd_en),
        .in_empty    (in_empty),
        .in_dout     (in_dout),
        .out_wr_en   (out_wr_en),
        .out_full    (out_full),
        .out_din     (out_din),
        .out_wr_en_2 (out_wr_en_2),
        .out_full_2  (out_full_2),
        .out_din_2   (out_din_2),
        .swap_iq     (swap_iq),
        .sample_count(sample_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        longint i;
        longint q;
    } pair_t;

    typedef struct {
        logic [63:0] word;
        bit          swap;
        longint      i0, q0, i1, q1;
    } vec_t;

    int          n_checks;
    int          n_fail;
    pair_t       exp_q[$];
    logic [63:0] in_q[$];
    longint      n_pairs;
    int          step_no;
    bit          wrote;
    bit          popped;
    bit          cur_swap;
    bit          full1;
    bit          full2;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (step %0d)", name, act, exp, step_no);
        end
    endtask

    task automatic report_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (step %0d)", name, step_no);
    endtask

    // Reference conversion: signed sample times 2^QUANT_BITS.
    function automatic longint conv(input logic [SAMPLE_WIDTH-1:0] s);
        return longint'($signed(s)) * (longint'(1) << QUANT_BITS);
    endfunction

    // Queue a word into the input FIFO and its expected pairs into the model.
    task automatic push(input logic [63:0] w, input bit sw);
        pair_t  p;
        longint a, b;
        in_q.push_back(w);
        for (int k = 0; k < PAIRS; k++) begin
            a = conv(w[k*2*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            b = conv(w[k*2*SAMPLE_WIDTH + SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            p.i = sw ? b : a;
            p.q = sw ? a : b;
            exp_q.push_back(p);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later.
    task automatic step();
        pair_t e;
        in_empty   = (in_q.size() == 0);
        in_dout    = in_empty ? '0 : in_q[0];
        out_full   = full1;
        out_full_2 = full2;
        swap_iq    = cur_swap;
        #1;
        wrote  = out_wr_en;
        popped = in_rd_en;
        if (out_wr_en || out_wr_en_2) chk("wr_en_lockstep", out_wr_en, out_wr_en_2);
        if (full1 || full2) chk("no_write_when_full", out_wr_en, 0);
        if (in_empty) chk("no_pop_when_empty", in_rd_en, 0);
        if (out_wr_en) begin
            if (exp_q.size() == 0) begin
                report_fail("unexpected_write");
            end else begin
                e = exp_q.pop_front();
                chk("out_din_i", longint'($signed(out_din)), e.i);
                chk("out_din_q", longint'($signed(out_din_2)), e.q);
            end
            n_pairs++;
        end
        if (in_rd_en && !in_empty) void'(in_q.pop_front());
        step_no++;
        @(negedge clock);
    endtask

    task automatic drain(input int bound, input string name, input bit rand_full);
        int s;
        s = 0;
        while (exp_q.size() > 0 && s < bound) begin
            if (rand_full) begin
                full1 = ($urandom_range(0, 3) == 0);
                full2 = ($urandom_range(0, 3) == 0);
            end
            step();
            s++;
        end
        full1 = 1'b0;
        full2 = 1'b0;
        if (exp_q.size() > 0) report_fail(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        pair_t       p;
        longint      base;
        int          pop_step, first_wr, last_wr, writes, s;
        logic [63:0] w;

        n_checks = 0;
        n_fail   = 0;
        n_pairs  = 0;
        step_no  = 0;
        cur_swap = 1'b0;
        full1    = 1'b0;
        full2    = 1'b0;

        vecs[0] = '{64'h0003_FFFE_0002_0001, 1'b0, 1024, 2048, -2048, 3072};
        vecs[1] = '{64'h7FFF_8000_8000_7FFF, 1'b1, -33554432, 33553408, 33553408, -33554432};
        vecs[2] = '{64'h0000_0000_FFFF_FFFF, 1'b0, -1024, -1024, 0, 0};
        vecs[3] = '{64'h1234_0001_0000_8000, 1'b1, 0, -33554432, 4771840, 1024};

        // Reset held with a non-empty input FIFO.
        reset      = 1'b0;
        in_empty   = 1'b0;
        in_dout    = 64'hDEAD_BEEF_1234_5678;
        out_full   = 1'b0;
        out_full_2 = 1'b0;
        swap_iq    = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("reset_in_rd_en", in_rd_en, 0);
        chk("reset_out_wr_en", out_wr_en, 0);
        chk("reset_out_wr_en_2", out_wr_en_2, 0);
        chk("reset_sample_count", longint'(sample_count), 0);
        chk("reset_out_din", longint'(out_din), 0);
        chk("reset_out_din_2", longint'(out_din_2), 0);
        in_empty = 1'b1;
        reset    = 1'b1;
        @(negedge clock);

        // Directed vectors, one word at a time.
        foreach (vecs[v]) begin
            base = longint'(sample_count);
            in_q.push_back(vecs[v].word);
            p.i = vecs[v].i0; p.q = vecs[v].q0; exp_q.push_back(p);
            p.i = vecs[v].i1; p.q = vecs[v].q1; exp_q.push_back(p);
            cur_swap = vecs[v].swap;
            pop_step = -1; first_wr = -1; last_wr = -1; s = 0;
            while (exp_q.size() > 0 && s < 10) begin
                step();
                if (popped && pop_step < 0) pop_step = step_no - 1;
                if (wrote) begin
                    if (first_wr < 0) first_wr = step_no - 1;
                    last_wr = step_no - 1;
                end
                s++;
            end
            if (exp_q.size() > 0) report_fail("vector_timeout");
            chk("vec_latency", first_wr - pop_step, 1);
            chk("vec_consecutive", last_wr - first_wr, PAIRS - 1);
            chk("vec_sample_count", longint'(sample_count), base + PAIRS);
            step();
            chk("vec_idle_after_word", wrote, 0);
        end

        // Streaming: 256 random words, no backpressure.
        cur_swap = 1'b0;
        base = longint'(sample_count);
        for (int k = 0; k < 256; k++) push({$urandom, $urandom}, 1'b0);
        s = 0;
        popped = 1'b0;
        while (!popped && s < 5) begin
            step();
            s++;
        end
        if (!popped) report_fail("stream_first_pop");
        writes = 0;
        repeat (512) begin
            step();
            writes += int'(wrote);
        end
        chk("stream_writes", writes, 512);
        chk("stream_model_empty", exp_q.size(), 0);
        chk("stream_sample_count", longint'(sample_count), base + 512);

        // Backpressure: Q FIFO full for 5 cycles between pair 0 and pair 1.
        base = longint'(sample_count);
        push({$urandom, $urandom}, 1'b0);
        push({$urandom, $urandom}, 1'b0);
        step();
        chk("bp_pop", popped, 1);
        step();
        chk("bp_pair0", wrote, 1);
        full2 = 1'b1;
        repeat (5) begin
            step();
            chk("bp_stall_no_write", wrote, 0);
            chk("bp_stall_no_pop", popped, 0);
            chk("bp_stall_hold_i", longint'($signed(out_din)), exp_q[0].i);
        end
        full2 = 1'b0;
        step();
        chk("bp_resume_write", wrote, 1);
        chk("bp_resume_reload", popped, 1);
        drain(20, "bp_drain", 1'b0);
        chk("bp_sample_count", longint'(sample_count), base + 2 * PAIRS);

        // Random backpressure on both outputs with swap enabled.
        cur_swap = 1'b1;
        base = longint'(sample_count);
        for (int k = 0; k < 64; k++) push({$urandom, $urandom}, 1'b1);
        drain(3000, "randbp_drain", 1'b1);
        chk("randbp_sample_count", longint'(sample_count), base + 64 * PAIRS);

        // Swap toggled mid-word: first word keeps swap=1, next word sees swap=0.
        w = {$urandom, $urandom};
        push(64'h7FFF_8000_8000_7FFF, 1'b1);
        push(w, 1'b0);
        cur_swap = 1'b1;
        step();
        chk("swap_pop", popped, 1);
        cur_swap = 1'b0;
        drain(20, "swap_drain", 1'b0);

        // Reset in the middle of a word discards its remaining pair.
        step();
        push({$urandom, $urandom}, 1'b0);
        step();
        step();
        chk("mid_pair0", wrote, 1);
        reset = 1'b0;
        #1;
        chk("mid_reset_count", longint'(sample_count), 0);
        chk("mid_reset_wr_en", out_wr_en, 0);
        chk("mid_reset_out_din", longint'(out_din), 0);
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        in_q.delete();
        n_pairs = 0;
        push(64'h0003_FFFE_0002_0001, 1'b0);
        drain(20, "mid_drain", 1'b0);
        chk("mid_after_count", longint'(sample_count), PAIRS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/read_iq_param.md
# read_iq_param

Parametrised IQ unpacker that sits between the raw-sample input FIFO and the I and Q channel FIFOs at the head of the FM demodulation chain. It pops packed words, splits each into one or more signed I/Q sample pairs, sign-extends and left-shifts (quantises) each sample, and writes I and Q to their FIFOs in lockstep. Compared with the fixed single-format unpacker, it generalises input width, sample width, and quantisation. It also adds a per-word I/Q swap mode, a full-throughput back-to-back path, and a running sample counter.

## Interface
- IN_WIDTH, 64: input word width; must be a multiple of 2*SAMPLE_WIDTH.
- SAMPLE_WIDTH, 16: width of each signed I or Q sample in the packed word.
- QUANT_BITS, 10: left shift applied after sign extension.
- OUT_WIDTH, 32: output sample width; SAMPLE_WIDTH+QUANT_BITS ≤ OUT_WIDTH.
- PAIRS (derived), IN_WIDTH/(2*SAMPLE_WIDTH): pairs per word; ≥1.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_rd_en  out  1  pop from input FIFO.
- in_empty  in  1  input FIFO empty.
- in_dout  in  IN_WIDTH  input FIFO head word, first-word-fall-through (valid while !in_empty).
- out_wr_en  out  1  write to I FIFO.
- out_full  in  1  I FIFO full.
- out_din  out  OUT_WIDTH  signed I sample.
- out_wr_en_2  out  1  write to Q FIFO.
- out_full_2  in  1  Q FIFO full.
- out_din_2  out  OUT_WIDTH  signed Q sample.
- swap_iq  in  1  exchange I and Q; sampled when a word is popped.
- sample_count  out  32  number of pairs written since reset.

## Operation
- Pair k, for k = 0..PAIRS-1, occupies in_dout[k*2*SAMPLE_WIDTH +: 2*SAMPLE_WIDTH].
  - I is the low SAMPLE_WIDTH bits of the pair; Q is the high SAMPLE_WIDTH bits.
  - Pairs are emitted in ascending k.
- Conversion: out = sign_extend(sample, OUT_WIDTH) <<< QUANT_BITS. Exact; no saturation needed given the width constraint.
- Registers:
  - word_r: captured input word.
  - swap_r: swap_iq captured at pop.
  - idx_r: current pair index, 0..PAIRS-1.
  - state.
  - count_r: drives sample_count.
- FSM states:
  - S_LOAD: in_rd_en = !in_empty. On pop: capture in_dout into word_r and swap_iq into swap_r, set idx_r=0, go to S_EMIT.
  - S_EMIT: define wr_ok = !out_full && !out_full_2. When wr_ok, out_wr_en and out_wr_en_2 are both 1 (combinational), driving pair idx_r of word_r, swapped if swap_r.
    - Non-last pair (idx_r<PAIRS-1): idx_r++.
    - Last pair with !in_empty: in_rd_en=1 in the same cycle; reload word_r, swap_r, idx_r=0; stay in S_EMIT (no bubble).
    - Last pair with in_empty: go to S_LOAD.
    - !wr_ok: no writes, no pop, all registers hold.
- out_wr_en and out_wr_en_2 are always equal. A pair is never split across cycles, duplicated, or dropped.
- count_r increments by 1 per written pair; it wraps from 2^32-1 to 0.
- swap_iq changes take effect only at the next word boundary.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=S_LOAD; word_r, idx_r, swap_r, count_r = 0.
  - in_rd_en, out_wr_en, out_wr_en_2 = 0; out_din and out_din_2 = 0; sample_count = 0.
- Latency: a word popped in cycle t has its pair 0 written in cycle t+1 when wr_ok.
- Throughput: 1 pair/cycle sustained while the input is non-empty and both outputs are non-full.
- After the initial load, each word takes PAIRS cycles.
- out_din and out_din_2 are combinational from registers and valid whenever the write enables are high. They hold their value while stalled.
- Reset mid-word discards the remaining pairs of word_r. The next word after reset starts at pair 0.
- A full flag on either output stalls both channels.
- in_empty going high during S_EMIT has effect only at the last pair.

## Test plan
- Reset: hold reset low 3 cycles with in_empty=0 → in_rd_en, out_wr_en, out_wr_en_2 = 0; sample_count=0; out_din and out_din_2 = 0.
- Single word 64'h0003_FFFE_0002_0001, swap_iq=0 → writes (I,Q) = (1024,2048), then (-2048,3072), on consecutive cycles; sample_count=2; FSM returns to S_LOAD.
- Streaming: 256 random words, outputs never full → 512 pairs in 512 consecutive cycles after the first pop; sample_count=512; I/Q match the software model.
- Backpressure: assert out_full_2 alone for 5 cycles between pair 0 and pair 1 → no write on either FIFO and no pop; pair 1 is written in the first cycle after release; no duplication or loss.
- Swap and extremes: word 64'h7FFF_8000_8000_7FFF with swap_iq=1 → (I,Q) = (-33554432, 33553408), then (33553408, -33554432). Toggle swap_iq mid-word → no effect until the next word.
- Reset mid-word: assert reset after pair 0 of a 2-pair word → no pair 1 write; sample_count=0; the next word's pair 0 is emitted first.
